// File: rtl/risc_pkg.sv
// Shared types and constants for the RV32I multi-cycle core.
package risc_pkg;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OPCODE_R_TYPE       = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPCODE_I_TYPE_ALU   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPCODE_I_TYPE_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPCODE_I_TYPE_JALR  = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPCODE_S_TYPE       = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPCODE_B_TYPE       = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPCODE_U_TYPE_LUI   = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPCODE_U_TYPE_AUIPC = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPCODE_J_TYPE       = 7'b1101111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_TARGET = 2'd1,
    PC_ALU    = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  // Registered control outputs that depend only on the state being entered
  typedef struct packed {
    logic    mem_req;
    logic    mem_we;
    logic    addr_sel;
    logic    pc_we;
    pc_sel_t pc_sel;
    logic    rf_we;
    wb_sel_t wb_sel;
    logic    busy;
    logic    halt;
  } ctrl_out_t;

  // Counter width able to hold the wait limit itself
  function automatic int unsigned tmo_cnt_width(input int unsigned limit);
    return $unsigned($clog2(limit + 1));
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts memory wait cycles; expired_o flags the last permitted wait cycle.
module mem_timeout_cnt
  import risc_pkg::*;
#(
  parameter  int unsigned MEM_TIMEOUT = 16,
  localparam int unsigned CW          = tmo_cnt_width(MEM_TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] limit_i,
  output logic          expired_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // The cycle that holds limit-1 completed waits is the limit-th wait cycle
  assign expired_o = (cnt_q == limit_i - CW'(1));

  // Clear on access start, advance on every unanswered wait cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with trap handling.
module multicycle_ctrl
  import risc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                r_type_i,
  input  logic                i_type_i,
  input  logic                s_type_i,
  input  logic                b_type_i,
  input  logic                u_type_i,
  input  logic                j_type_i,
  input  logic                branch_taken_i,
  input  logic                mem_ready_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic                addr_sel_o,
  output logic                ir_we_o,
  output logic                pc_we_o,
  output logic [1:0]          pc_sel_o,
  output logic                rf_we_o,
  output logic [1:0]          wb_sel_o,
  output logic                busy_o,
  output logic                halt_o,
  output logic [CNT_W-1:0]    retired_o
);

  localparam int unsigned TMO_W = tmo_cnt_width(MEM_TIMEOUT);

  ctrl_state_t      state_q, state_d;
  ctrl_out_t        out_q, out_d;
  logic             fetch_q, fetch_d;
  logic             store_q, store_d;
  logic             branch_q, branch_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic any_class;
  logic is_load;
  logic is_jalr;
  logic is_jal;
  logic waiting;
  logic expired;
  logic tmo_clr;
  logic retire;

  assign any_class = r_type_i | i_type_i | s_type_i | b_type_i | u_type_i | j_type_i;
  assign is_load   = i_type_i && (opcode_i == OPCODE_I_TYPE_LOAD);
  assign is_jalr   = i_type_i && (opcode_i == OPCODE_I_TYPE_JALR);
  assign is_jal    = j_type_i;

  // Wait cycles are memory states without a completion this cycle
  assign waiting = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready_i;
  assign tmo_clr = (state_d != state_q);

  mem_timeout_cnt #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmo_clr),
    .en_i     (waiting),
    .limit_i  (TMO_W'(MEM_TIMEOUT)),
    .expired_o(expired)
  );

  // Next-state and retire decode
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        if (mem_ready_i) begin
          state_d = DECODE;
        end else if (expired) begin
          state_d = TRAP;
        end
      end
      DECODE: state_d = any_class ? EXEC : TRAP;
      EXEC: begin
        if (b_type_i) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else if (is_load || s_type_i) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (mem_ready_i) begin
          if (s_type_i) begin
            state_d = FETCH;
            retire  = 1'b1;
          end else begin
            state_d = WB;
          end
        end else if (expired) begin
          state_d = TRAP;
        end
      end
      WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // Output look-ahead: decode the state being entered so outputs leave flops
  always_comb begin
    out_d    = '0;
    fetch_d  = 1'b0;
    store_d  = 1'b0;
    branch_d = 1'b0;
    case (state_d)
      FETCH: begin
        out_d.mem_req = 1'b1;
        out_d.busy    = 1'b1;
        fetch_d       = 1'b1;
      end
      DECODE: begin
        out_d.busy = 1'b1;
      end
      EXEC: begin
        out_d.busy = 1'b1;
        if (b_type_i) begin
          out_d.pc_we = 1'b1;
          branch_d    = 1'b1;
        end
      end
      MEM: begin
        out_d.mem_req  = 1'b1;
        out_d.addr_sel = 1'b1;
        out_d.mem_we   = s_type_i;
        out_d.busy     = 1'b1;
        store_d        = s_type_i;
      end
      WB: begin
        out_d.rf_we = 1'b1;
        out_d.pc_we = 1'b1;
        out_d.busy  = 1'b1;
        if (is_load) begin
          out_d.wb_sel = WB_MEM;
        end else if (is_jal || is_jalr) begin
          out_d.wb_sel = WB_PC4;
        end else begin
          out_d.wb_sel = WB_ALU;
        end
        if (is_jal) begin
          out_d.pc_sel = PC_TARGET;
        end else if (is_jalr) begin
          out_d.pc_sel = PC_ALU;
        end else begin
          out_d.pc_sel = PC_PLUS4;
        end
      end
      TRAP: begin
        out_d.halt = 1'b1;
      end
      default: ;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  // State, registered outputs and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_q     <= '0;
      fetch_q   <= 1'b0;
      store_q   <= 1'b0;
      branch_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      fetch_q   <= fetch_d;
      store_q   <= store_d;
      branch_q  <= branch_d;
      retired_q <= retired_d;
    end
  end

  // Handshake-qualified strobes combine a registered qualifier with mem_ready
  assign ir_we_o    = fetch_q & mem_ready_i;
  assign pc_we_o    = out_q.pc_we | (store_q & mem_ready_i);
  assign pc_sel_o   = (branch_q && branch_taken_i) ? PC_TARGET : out_q.pc_sel;
  assign mem_req_o  = out_q.mem_req;
  assign mem_we_o   = out_q.mem_we;
  assign addr_sel_o = out_q.addr_sel;
  assign rf_we_o    = out_q.rf_we;
  assign wb_sel_o   = out_q.wb_sel;
  assign busy_o     = out_q.busy;
  assign halt_o     = out_q.halt;
  assign retired_o  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl.
module tb_multicycle_ctrl;
  import risc_pkg::*;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        r_type, i_type, s_type, b_type, u_type, j_type;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, busy, halt;
  logic [1:0]  pc_sel, wb_sel;
  logic [31:0] retired;
  logic [11:0] ctl;

  int n_vec = 0;
  int n_err = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode_i      (opcode),
    .r_type_i      (r_type),
    .i_type_i      (i_type),
    .s_type_i      (s_type),
    .b_type_i      (b_type),
    .u_type_i      (u_type),
    .j_type_i      (j_type),
    .branch_taken_i(branch_taken),
    .mem_ready_i   (mem_ready),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .addr_sel_o    (addr_sel),
    .ir_we_o       (ir_we),
    .pc_we_o       (pc_we),
    .pc_sel_o      (pc_sel),
    .rf_we_o       (rf_we),
    .wb_sel_o      (wb_sel),
    .busy_o        (busy),
    .halt_o        (halt),
    .retired_o     (retired)
  );

  assign ctl = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel, busy, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: settle, compare every control output, move to the next cycle
  task automatic cyc(input string tag, input logic req, input logic we, input logic asel,
                     input logic irwe, input logic pcwe, input logic [1:0] psel,
                     input logic rfwe, input logic [1:0] wsel, input logic bsy, input logic hlt);
    logic [11:0] exp;
    exp = {req, we, asel, irwe, pcwe, psel, rfwe, wsel, bsy, hlt};
    #1;
    chk(tag, 32'(ctl), 32'(exp));
    @(negedge clk);
  endtask

  // Decoder model: opcode class flags for an instruction word
  task automatic set_instr(input logic [31:0] word);
    opcode = word[6:0];
    {r_type, i_type, s_type, b_type, u_type, j_type} = 6'b0;
    case (word[6:0])
      7'h33:                r_type = 1'b1;
      7'h13, 7'h03, 7'h67:  i_type = 1'b1;
      7'h23:                s_type = 1'b1;
      7'h63:                b_type = 1'b1;
      7'h37, 7'h17:         u_type = 1'b1;
      7'h6F:                j_type = 1'b1;
      default: ;
    endcase
  endtask

  // Reset, check forced values, release, check IDLE; returns in the first FETCH cycle
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", 32'(ctl), 32'h0);
    chk("rst_retired", retired, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_ctl", 32'(ctl), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b1;
    mem_ready    = 1'b1;
    branch_taken = 1'b0;
    set_instr(32'h0);
    @(negedge clk);
    do_reset();

    // ADDI
    set_instr(32'h00500093);
    cyc("addi_fetch", I,O,O,I,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("addi_dec",   O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("addi_exec",  O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    chk("addi_ret_pre", retired, 32'd0);
    cyc("addi_wb",    O,O,O,O,I,PC_PLUS4,I,WB_ALU,I,O);
    chk("addi_ret", retired, 32'd1);

    // LW with three wait cycles in MEM
    set_instr(32'h0000A103);
    cyc("lw_fetch", I,O,O,I,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("lw_dec",   O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("lw_exec",  O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) cyc("lw_mem_wait", I,O,I,O,O,PC_PLUS4,O,WB_ALU,I,O);
    mem_ready = 1'b1;
    cyc("lw_mem_done", I,O,I,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("lw_wb",       O,O,O,O,I,PC_PLUS4,I,WB_MEM,I,O);
    chk("lw_ret", retired, 32'd2);

    // SW
    set_instr(32'h0020A023);
    cyc("sw_fetch", I,O,O,I,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("sw_dec",   O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("sw_exec",  O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("sw_mem",   I,I,I,O,I,PC_PLUS4,O,WB_ALU,I,O);
    chk("sw_ret", retired, 32'd3);

    // BEQ taken
    set_instr(32'h00208463);
    branch_taken = 1'b1;
    cyc("beqt_fetch", I,O,O,I,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("beqt_dec",   O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("beqt_exec",  O,O,O,O,I,PC_TARGET,O,WB_ALU,I,O);
    chk("beqt_ret", retired, 32'd4);

    // BEQ not taken
    branch_taken = 1'b0;
    cyc("beqn_fetch", I,O,O,I,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("beqn_dec",   O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("beqn_exec",  O,O,O,O,I,PC_PLUS4,O,WB_ALU,I,O);
    chk("beqn_ret", retired, 32'd5);

    // JAL
    set_instr(32'h0080006F);
    cyc("jal_fetch", I,O,O,I,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("jal_dec",   O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("jal_exec",  O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("jal_wb",    O,O,O,O,I,PC_TARGET,I,WB_PC4,I,O);

    // JALR
    set_instr(32'h000080E7);
    cyc("jalr_fetch", I,O,O,I,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("jalr_dec",   O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("jalr_exec",  O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("jalr_wb",    O,O,O,O,I,PC_ALU,I,WB_PC4,I,O);
    chk("jalr_ret", retired, 32'd7);

    // Illegal opcode traps after DECODE
    set_instr(32'h0000007F);
    cyc("ill_fetch", I,O,O,I,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("ill_dec",   O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    for (int k = 0; k < 3; k++) cyc("ill_trap", O,O,O,O,O,PC_PLUS4,O,WB_ALU,O,I);
    chk("ill_ret", retired, 32'd7);
    do_reset();

    // mem_ready stuck low in FETCH: 16 wait cycles, then TRAP
    set_instr(32'h00500093);
    mem_ready = 1'b0;
    for (int k = 0; k < 16; k++) cyc("tmo_wait", I,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("tmo_trap", O,O,O,O,O,PC_PLUS4,O,WB_ALU,O,I);
    mem_ready = 1'b1;
    cyc("tmo_trap_hold", O,O,O,O,O,PC_PLUS4,O,WB_ALU,O,I);
    do_reset();

    // mem_ready on the last permitted wait cycle completes the fetch
    mem_ready = 1'b0;
    for (int k = 0; k < 15; k++) cyc("edge_wait", I,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    mem_ready = 1'b1;
    cyc("edge_fetch", I,O,O,I,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("edge_dec",   O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("edge_exec",  O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("edge_wb",    O,O,O,O,I,PC_PLUS4,I,WB_ALU,I,O);
    chk("edge_ret", retired, 32'd1);

    // Reset asserted mid-MEM of a store
    set_instr(32'h0020A023);
    cyc("mid_fetch", I,O,O,I,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("mid_dec",   O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    cyc("mid_exec",  O,O,O,O,O,PC_PLUS4,O,WB_ALU,I,O);
    mem_ready = 1'b0;
    cyc("mid_mem",   I,I,I,O,O,PC_PLUS4,O,WB_ALU,I,O);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'(ctl), 32'h0);
    chk("mid_rst_ret", retired, 32'd0);
    @(negedge clk);
    mem_ready = 1'b1;
    do_reset();
    cyc("post_fetch", I,O,O,I,O,PC_PLUS4,O,WB_ALU,I,O);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
